aes256_dualrail_trace_sequencer: RTL and testbench

Sequences repeated encryptions on the dual-rail (true/false) AES-256 core for side-channel trace campaigns.
- Generates plaintext on both rails and drives the core's precharge/evaluate reset.
- Captures the core's dual-rail ciphertext and checks rail complementarity.
- Inserts a programmable gap between traces and emits a scope trigger.
- Sits between the campaign host/top level and the AES-256 dual-rail core.

---
 rtl/aes256_dualrail_trace_sequencer_if.sv | 40 ++++
 rtl/aes256_dualrail_trace_sequencer.sv | 123 ++++++++++++
 tb/tb_aes256_dualrail_trace_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes256_dualrail_trace_sequencer_if.sv
// Campaign host and dual-rail AES core signals for the trace sequencer.
// The slave modport is the sequencer; the master modport is the host/core side.
interface aes256_dualrail_trace_sequencer_if #(
  parameter int N     = 128,
  parameter int CNT_W = 16
);
  logic             Start;
  logic [CNT_W-1:0] Num_traces;
  logic [9:0]       Gap_cycles;
  logic             Chain_mode;
  logic [N-1:0]     Seed;
  logic [N-1:0]     Cipher_in_T;
  logic [N-1:0]     Cipher_in_F;
  logic             Done;
  logic             Flag_in;
  logic             Core_Reset;
  logic [N-1:0]     Plain_Text_T;
  logic [N-1:0]     Plain_Text_F;
  logic             Trigger;
  logic             Busy;
  logic             Finished;
  logic [CNT_W-1:0] Trace_count;
  logic [CNT_W-1:0] Fault_count;
  logic             Timeout_err;
  logic [N-1:0]     Last_Cipher_T;

  modport slave (
    input  Start, Num_traces, Gap_cycles, Chain_mode, Seed,
           Cipher_in_T, Cipher_in_F, Done, Flag_in,
    output Core_Reset, Plain_Text_T, Plain_Text_F, Trigger, Busy, Finished,
           Trace_count, Fault_count, Timeout_err, Last_Cipher_T
  );

  modport master (
    output Start, Num_traces, Gap_cycles, Chain_mode, Seed,
           Cipher_in_T, Cipher_in_F, Done, Flag_in,
    input  Core_Reset, Plain_Text_T, Plain_Text_F, Trigger, Busy, Finished,
           Trace_count, Fault_count, Timeout_err, Last_Cipher_T
  );
endinterface

// File: rtl/aes256_dualrail_trace_sequencer.sv
// Runs repeated precharge/evaluate/capture cycles on a dual-rail AES-256 core,
// generating plaintexts, checking rail complementarity and pacing scope triggers.
module aes256_dualrail_trace_sequencer #(
  parameter int N                = 128,
  parameter int CNT_W            = 16,
  parameter int PRECHARGE_CYCLES = 4,
  parameter int TIMEOUT          = 1023
) (
  input logic Clk,
  input logic ResetAll_n,
  aes256_dualrail_trace_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PRE, EVAL, CAP, GAP, FIN} state_t;

  localparam int CW = 16;
  localparam logic [N-1:0] POLY = N'(8'h87);

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic             done_q, flag_q;
  logic [CNT_W-1:0] num_traces_r, trace_count, fault_count;
  logic [9:0]       gap_r, gap_len;
  logic             chain_r;
  logic [N-1:0]     plain_t, last_cipher, lfsr_next;
  logic             finished, timeout_err;
  logic             rail_fault;

  // Galois step; the all-zero state would lock up, so it restarts at 1.
  always_comb begin
    lfsr_next = {plain_t[N-2:0], 1'b0} ^ (plain_t[N-1] ? POLY : '0);
    if (plain_t == '0) lfsr_next = N'(1);
  end

  assign gap_len    = (gap_r == 10'd0) ? 10'd1 : gap_r;
  assign rail_fault = (bus.Cipher_in_T != ~bus.Cipher_in_F);

  always_comb begin
    next_state     = state;
    bus.Core_Reset = 1'b1;
    bus.Trigger    = 1'b0;
    bus.Busy       = 1'b0;
    case (state)
      IDLE: if (bus.Start) next_state = (bus.Num_traces == '0) ? FIN : PRE;
      PRE: begin
        bus.Busy = 1'b1;
        if (cnt == CW'(PRECHARGE_CYCLES - 1)) next_state = EVAL;
      end
      EVAL: begin
        bus.Busy       = 1'b1;
        bus.Core_Reset = 1'b0;
        bus.Trigger    = (cnt == '0);
        if (done_q && flag_q)              next_state = CAP;
        else if (cnt == CW'(TIMEOUT - 1))  next_state = FIN;
      end
      CAP: begin
        bus.Busy   = 1'b1;
        next_state = ((trace_count + CNT_W'(1)) == num_traces_r) ? FIN : GAP;
      end
      GAP: begin
        bus.Busy = 1'b1;
        if (cnt == (CW'(gap_len) - CW'(1))) next_state = PRE;
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The phase counter restarts on every state change and is shared by PRE, EVAL and GAP.
  always_ff @(posedge Clk) begin
    if (!ResetAll_n) begin
      state        <= IDLE;
      cnt          <= '0;
      done_q       <= 1'b0;
      flag_q       <= 1'b0;
      num_traces_r <= '0;
      gap_r        <= '0;
      chain_r      <= 1'b0;
      plain_t      <= '0;
      last_cipher  <= '0;
      trace_count  <= '0;
      fault_count  <= '0;
      finished     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= bus.Done;
      flag_q <= bus.Flag_in;
      if (next_state != state) cnt <= '0;
      else if (cnt != '1)      cnt <= cnt + CW'(1);
      case (state)
        IDLE: if (bus.Start) begin
          num_traces_r <= bus.Num_traces;
          gap_r        <= bus.Gap_cycles;
          chain_r      <= bus.Chain_mode;
          plain_t      <= bus.Seed;
          trace_count  <= '0;
          fault_count  <= '0;
          finished     <= 1'b0;
          timeout_err  <= 1'b0;
        end
        EVAL: if (next_state == FIN) timeout_err <= 1'b1;
        CAP: begin
          last_cipher <= bus.Cipher_in_T;
          trace_count <= trace_count + CNT_W'(1);
          if (rail_fault && (fault_count != '1)) fault_count <= fault_count + CNT_W'(1);
          plain_t <= chain_r ? bus.Cipher_in_T : lfsr_next;
        end
        default: ;
      endcase
      if (next_state == FIN) finished <= 1'b1;
    end
  end

  assign bus.Plain_Text_T  = plain_t;
  assign bus.Plain_Text_F  = ~plain_t;
  assign bus.Finished      = finished;
  assign bus.Trace_count   = trace_count;
  assign bus.Fault_count   = fault_count;
  assign bus.Timeout_err   = timeout_err;
  assign bus.Last_Cipher_T = last_cipher;

endmodule

// File: tb/tb_aes256_dualrail_trace_sequencer.sv
// Directed bench for the trace sequencer with a stub dual-rail core that answers
// 10 cycles after evaluate starts and returns Plain_Text_T ^ A5..A5.
module tb_aes256_dualrail_trace_sequencer;
  localparam int N     = 128;
  localparam int CNT_W = 16;
  localparam logic [N-1:0] PAT  = {16{8'hA5}};
  localparam logic [N-1:0] ONES = '1;

  logic Clk = 1'b0;
  logic ResetAll_n;
  always #5 Clk = ~Clk;

  aes256_dualrail_trace_sequencer_if #(.N(N), .CNT_W(CNT_W)) bus ();

  aes256_dualrail_trace_sequencer #(
    .N(N), .CNT_W(CNT_W), .PRECHARGE_CYCLES(4), .TIMEOUT(1023)
  ) dut (
    .Clk(Clk),
    .ResetAll_n(ResetAll_n),
    .bus(bus.slave)
  );

  typedef struct {
    logic [N-1:0] seed;
    int           num;
    int           gap;
    logic         chain;
    int           fault_trace;
    logic         done_en;
    int           exp_trace;
    int           exp_fault;
    logic         exp_tout;
    int           exp_trig;
    int           exp_eval;
    int           exp_period;
    logic [N-1:0] exp_pt2;
    logic [N-1:0] exp_pt3;
    logic [N-1:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  logic done_en;
  int   fault_trace;
  bit   stub_done;
  int   stub_cnt;
  int   trig_total, eval_total, compl_total, cyc;
  int   trig_base, eval_base, compl_base;
  logic [N-1:0] pt_log[$];
  int   trig_cyc[$];
  int   total, passed;
  logic flip;

  // Stub core: Done/Flag rise 10 cycles after Core_Reset falls and hold until precharge.
  always @(posedge Clk) begin
    if (bus.Core_Reset !== 1'b0) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (done_en && stub_cnt == 9) stub_done <= 1'b1;
    end
  end

  assign flip            = (fault_trace != 0) && ((trig_total - trig_base) == fault_trace);
  assign bus.Done        = stub_done;
  assign bus.Flag_in     = stub_done;
  assign bus.Cipher_in_T = bus.Plain_Text_T ^ PAT;
  assign bus.Cipher_in_F = ~(bus.Plain_Text_T ^ PAT) ^ {{(N-1){1'b0}}, flip};

  always @(posedge Clk) begin
    cyc = cyc + 1;
    if (bus.Trigger === 1'b1) begin
      trig_total = trig_total + 1;
      pt_log.push_back(bus.Plain_Text_T);
      trig_cyc.push_back(cyc);
    end
    if (bus.Core_Reset === 1'b0) eval_total = eval_total + 1;
    if (bus.Plain_Text_F !== ~bus.Plain_Text_T) compl_total = compl_total + 1;
  end

  task automatic checkOutput(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic doReset();
    ResetAll_n = 1'b0;
    bus.Start  = 1'b0;
    repeat (2) @(negedge Clk);
    ResetAll_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic applyStimulus(input logic [N-1:0] seed, input int num, input int gap, input logic chain);
    trig_base          = trig_total;
    eval_base          = eval_total;
    compl_base         = compl_total;
    bus.Seed           = seed;
    bus.Num_traces     = CNT_W'(num);
    bus.Gap_cycles     = 10'(gap);
    bus.Chain_mode     = chain;
    bus.Start          = 1'b1;
    @(negedge Clk);
    bus.Start          = 1'b0;
  endtask

  task automatic waitFinished(input string name, input int budget);
    int n;
    n = 0;
    while (bus.Finished !== 1'b1 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    checkOutput({name, "_finished"}, bus.Finished, 1);
  endtask

  task automatic waitTriggers(input int count, input int budget);
    int n;
    n = 0;
    while ((trig_total - trig_base) < count && n < budget) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("trigger_wait", trig_total - trig_base, count);
  endtask

  initial begin
    total = 0; passed = 0;
    cyc = 0; trig_total = 0; eval_total = 0; compl_total = 0;
    trig_base = 0; eval_base = 0; compl_base = 0;
    done_en = 1'b1; fault_trace = 0;
    ResetAll_n = 1'b0;
    bus.Start = 1'b0; bus.Num_traces = '0; bus.Gap_cycles = '0;
    bus.Chain_mode = 1'b0; bus.Seed = '0;

    //            seed            num gap ch ft done trc flt to trg eval per pt2          pt3      last
    vecs[0] = '{N'(1),             3, 5, 0, 0, 1, 3, 0, 0, 3, 36,  22, N'(2),       N'(4), N'(4) ^ PAT};
    vecs[1] = '{N'(1),             3, 5, 0, 2, 1, 3, 1, 0, 3, 36,  22, N'(2),       N'(4), N'(4) ^ PAT};
    vecs[2] = '{N'(1),             3, 5, 1, 0, 1, 3, 0, 0, 3, 36,  22, N'(1) ^ PAT, N'(1), N'(1) ^ PAT};
    vecs[3] = '{N'(1),             2, 5, 0, 0, 0, 0, 0, 1, 1, 1023, 0, '0,          '0,    '0};
    vecs[4] = '{{1'b1, {(N-1){1'b0}}}, 2, 0, 0, 0, 1, 2, 0, 0, 2, 24, 18, N'(8'h87), '0,    N'(8'h87) ^ PAT};
    vecs[5] = '{'0,                2, 1, 0, 0, 1, 2, 0, 0, 2, 24,  18, N'(1),       '0,    N'(1) ^ PAT};

    doReset();
    checkOutput("rst_core_reset", bus.Core_Reset, 1);
    checkOutput("rst_plain_t", bus.Plain_Text_T, '0);
    checkOutput("rst_plain_f", bus.Plain_Text_F, ONES);
    checkOutput("rst_busy", bus.Busy, 0);
    checkOutput("rst_finished", bus.Finished, 0);

    for (int i = 0; i < 6; i++) begin
      doReset();
      done_en     = vecs[i].done_en;
      fault_trace = vecs[i].fault_trace;
      applyStimulus(vecs[i].seed, vecs[i].num, vecs[i].gap, vecs[i].chain);
      waitFinished($sformatf("v%0d", i), 3000);
      @(negedge Clk);
      checkOutput($sformatf("v%0d_trace_count", i), bus.Trace_count, vecs[i].exp_trace);
      checkOutput($sformatf("v%0d_fault_count", i), bus.Fault_count, vecs[i].exp_fault);
      checkOutput($sformatf("v%0d_timeout", i), bus.Timeout_err, vecs[i].exp_tout);
      checkOutput($sformatf("v%0d_busy", i), bus.Busy, 0);
      checkOutput($sformatf("v%0d_core_reset", i), bus.Core_Reset, 1);
      checkOutput($sformatf("v%0d_triggers", i), trig_total - trig_base, vecs[i].exp_trig);
      checkOutput($sformatf("v%0d_eval_cycles", i), eval_total - eval_base, vecs[i].exp_eval);
      checkOutput($sformatf("v%0d_rail_compl", i), compl_total - compl_base, 0);
      checkOutput($sformatf("v%0d_last_cipher", i), bus.Last_Cipher_T, vecs[i].exp_last);
      if (trig_total - trig_base >= 1)
        checkOutput($sformatf("v%0d_pt1", i), pt_log[trig_base], vecs[i].seed);
      if (trig_total - trig_base >= 2) begin
        checkOutput($sformatf("v%0d_pt2", i), pt_log[trig_base + 1], vecs[i].exp_pt2);
        checkOutput($sformatf("v%0d_period", i), trig_cyc[trig_base + 1] - trig_cyc[trig_base], vecs[i].exp_period);
      end
      if (trig_total - trig_base >= 3)
        checkOutput($sformatf("v%0d_pt3", i), pt_log[trig_base + 2], vecs[i].exp_pt3);
    end

    // A second Start during a campaign must not change its length or seed.
    doReset();
    done_en = 1'b1; fault_trace = 0;
    applyStimulus(N'(1), 2, 5, 1'b0);
    waitTriggers(1, 200);
    bus.Num_traces = CNT_W'(5);
    bus.Seed       = N'(16'hBEEF);
    bus.Start      = 1'b1;
    @(negedge Clk);
    bus.Start      = 1'b0;
    waitFinished("busy_start", 500);
    checkOutput("busy_start_traces", bus.Trace_count, 2);
    checkOutput("busy_start_trig", trig_total - trig_base, 2);
    checkOutput("busy_start_pt2", pt_log[trig_base + 1], N'(2));

    // Zero-trace campaign: straight to FIN, no evaluate, counters cleared.
    @(negedge Clk);
    applyStimulus(N'(7), 0, 5, 1'b0);
    checkOutput("zero_busy", bus.Busy, 0);
    @(negedge Clk);
    checkOutput("zero_finished", bus.Finished, 1);
    checkOutput("zero_trace_count", bus.Trace_count, 0);
    checkOutput("zero_core_reset", bus.Core_Reset, 1);
    checkOutput("zero_trig", trig_total - trig_base, 0);
    checkOutput("zero_eval", eval_total - eval_base, 0);

    // Reset pulse in the middle of the second evaluate window.
    doReset();
    applyStimulus(N'(1), 3, 5, 1'b0);
    waitTriggers(2, 200);
    repeat (3) @(negedge Clk);
    checkOutput("midrst_in_eval", bus.Core_Reset, 0);
    ResetAll_n = 1'b0;
    @(negedge Clk);
    ResetAll_n = 1'b1;
    checkOutput("midrst_core_reset", bus.Core_Reset, 1);
    checkOutput("midrst_plain_t", bus.Plain_Text_T, '0);
    checkOutput("midrst_plain_f", bus.Plain_Text_F, ONES);
    checkOutput("midrst_trigger", bus.Trigger, 0);
    checkOutput("midrst_busy", bus.Busy, 0);
    checkOutput("midrst_finished", bus.Finished, 0);
    checkOutput("midrst_timeout", bus.Timeout_err, 0);
    checkOutput("midrst_trace_count", bus.Trace_count, 0);
    checkOutput("midrst_fault_count", bus.Fault_count, 0);
    checkOutput("midrst_last", bus.Last_Cipher_T, '0);
    @(negedge Clk);
    applyStimulus(N'(1), 3, 5, 1'b0);
    waitFinished("post_rst", 500);
    checkOutput("post_rst_traces", bus.Trace_count, 3);
    checkOutput("post_rst_last", bus.Last_Cipher_T, N'(4) ^ PAT);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
